// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares one data-memory port between the MEM stage (CPU)
// and a DMA/loader requester. The CPU has priority, but DMA is forced through
// after STARVE_MAX CPU completions. Each access holds the port for MEM_LAT cycles
// and is never preempted.
module dmem_port_arbiter #(
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [1:0]  i_cpu_ctrl,
  input  logic [31:0] i_cpu_addr,
  input  logic [31:0] i_cpu_wdata,
  output logic [31:0] o_cpu_rdata,
  output logic        o_cpu_stall,
  input  logic        i_dma_req,
  input  logic        i_dma_we,
  input  logic [31:0] i_dma_addr,
  input  logic [31:0] i_dma_wdata,
  output logic        o_dma_gnt,
  output logic        o_dma_rvalid,
  output logic [31:0] o_dma_rdata,
  output logic [1:0]  o_mem_ctrl,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [CW-1:0] LAST_CNT   = CW'(MEM_LAT - 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CPU  = 2'd1,
    ST_DMA  = 2'd2
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [SW-1:0]   r_starve;
  logic            r_dma_rvalid;
  logic [31:0]     r_dma_rdata;

  logic            w_idle;
  logic            w_cpu_req;
  logic [1:0]      w_cpu_cmd;
  logic [1:0]      w_dma_cmd;
  logic            w_pick_dma;
  logic            w_pick_cpu;
  logic            w_cpu_own;
  logic            w_dma_own;
  logic            w_last;
  logic            w_cpu_done;
  logic            w_dma_done;

  // Same-cycle arbitration in IDLE and port-ownership / completion decode.
  always_comb begin
    w_idle     = (r_state == ST_IDLE);
    w_cpu_req  = (i_cpu_ctrl != 2'b00);
    // {memread,memwrite}=11 is illegal; memread wins so it behaves as a load
    w_cpu_cmd  = i_cpu_ctrl[1] ? 2'b10 : i_cpu_ctrl;
    w_dma_cmd  = i_dma_we ? 2'b01 : 2'b10;
    w_pick_dma = w_idle && i_dma_req && (!w_cpu_req || (r_starve == STARVE_TOP));
    w_pick_cpu = w_idle && !w_pick_dma && w_cpu_req;
    w_cpu_own  = w_pick_cpu || (r_state == ST_CPU);
    w_dma_own  = w_pick_dma || (r_state == ST_DMA);
    // A single-cycle memory completes in the arbitration cycle itself
    w_last     = w_idle ? (MEM_LAT == 1) : (r_cnt == LAST_CNT);
    w_cpu_done = w_cpu_own && w_last;
    w_dma_done = w_dma_own && w_last;
  end

  // Memory command mux and requester-facing handshakes; reset blanks the handshakes.
  always_comb begin
    o_mem_addr  = w_dma_own ? i_dma_addr  : i_cpu_addr;
    o_mem_wdata = w_dma_own ? i_dma_wdata : i_cpu_wdata;
    if (i_reset) begin
      o_mem_ctrl  = 2'b00;
      o_cpu_stall = 1'b0;
      o_dma_gnt   = 1'b0;
      o_cpu_rdata = 32'd0;
    end else begin
      if (w_dma_own) begin
        o_mem_ctrl = w_dma_cmd;
      end else if (w_cpu_own) begin
        o_mem_ctrl = w_cpu_cmd;
      end else begin
        o_mem_ctrl = 2'b00;
      end
      o_cpu_stall = w_cpu_req && !w_cpu_done;
      o_dma_gnt   = w_dma_done;
      o_cpu_rdata = w_cpu_own ? i_mem_rdata : 32'd0;
    end
  end

  // Access sequencer, starvation counter and registered DMA read return.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_starve     <= '0;
      r_dma_rvalid <= 1'b0;
      r_dma_rdata  <= 32'd0;
    end else begin
      r_dma_rvalid <= w_dma_done && !i_dma_we;
      if (w_dma_done && !i_dma_we) begin
        r_dma_rdata <= i_mem_rdata;
      end

      case (r_state)
        ST_IDLE: begin
          if ((MEM_LAT > 1) && w_pick_dma) begin
            r_state <= ST_DMA;
            r_cnt   <= CW'(1);
          end else if ((MEM_LAT > 1) && w_pick_cpu) begin
            r_state <= ST_CPU;
            r_cnt   <= CW'(1);
          end else begin
            r_cnt   <= '0;
          end
        end
        ST_CPU, ST_DMA: begin
          if (w_last) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt   <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase

      // Starvation: cleared when DMA is chosen or not waiting, bumped per CPU win
      if (w_pick_dma) begin
        r_starve <= '0;
      end else if (w_idle && !i_dma_req) begin
        r_starve <= '0;
      end else if (w_cpu_done && i_dma_req && (r_starve < STARVE_TOP)) begin
        r_starve <= r_starve + SW'(1);
      end
    end
  end

  assign o_dma_rvalid = r_dma_rvalid;
  assign o_dma_rdata  = r_dma_rdata;

endmodule
